// File: rtl/env_trap_unit_pkg.sv
// Shared constants for the machine-mode trap responder: CSR addresses,
// mcause codes, mstatus bit positions and the trap FSM state encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE     = 2'd1,
        REDIRECT = 2'd2,
        RET      = 2'd3
    } trap_state_t;

endpackage

// File: rtl/env_trap_csr_file.sv
// M-mode CSR storage for the trap unit: read mux, write masking, and the
// rule that FSM-driven trap/return updates beat software CSR writes.
import csr_pkg::*;

module env_trap_csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter logic        RESET_MIE   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        save_en,
    input  logic [31:0] save_pc,
    input  logic [31:0] save_cause,
    input  logic [31:0] save_tval,
    input  logic        ret_en,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    localparam logic [31:0] MTVEC_INIT = RESET_MTVEC & ~32'd3;

    logic [31:0] mscratch;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        mie;
    logic        mpie;

    // Software writes are applied first; the FSM updates below are later
    // non-blocking assignments to the same registers and therefore win.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtvec    <= MTVEC_INIT;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mscratch <= '0;
            mie      <= RESET_MIE;
            mpie     <= 1'b0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie  <= csr_wdata[MSTATUS_MIE];
                        mpie <= csr_wdata[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:    mtvec    <= csr_wdata & ~32'd3;
                    CSR_MSCRATCH: mscratch <= csr_wdata;
                    CSR_MEPC:     mepc     <= csr_wdata & ~32'd3;
                    CSR_MCAUSE:   mcause   <= csr_wdata;
                    CSR_MTVAL:    mtval    <= csr_wdata;
                    default: ;
                endcase
            end
            if (save_en) begin
                mepc   <= save_pc & ~32'd3;
                mcause <= save_cause;
                mtval  <= save_tval;
                mpie   <= mie;
                mie    <= 1'b0;
            end
            if (ret_en) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = mie;
                csr_rdata[MSTATUS_MPIE] = mpie;
            end
            CSR_MTVEC:    csr_rdata = mtvec;
            CSR_MSCRATCH: csr_rdata = mscratch;
            CSR_MEPC:     csr_rdata = mepc;
            CSR_MCAUSE:   csr_rdata = mcause;
            CSR_MTVAL:    csr_rdata = mtval;
            default:      csr_rdata = '0;
        endcase
    end

endmodule

// File: rtl/env_trap_unit.sv
// Machine-mode trap responder: takes ECALL/EBREAK/MRET requests from the
// execute stage, saves trap state into the CSRs and issues a PC redirect.
import csr_pkg::*;

module env_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter logic        RESET_MIE   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_req,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        busy,
    output logic        trap_done,
    output logic        trap_overrun,
    output logic        reg_pc_w_op,
    output logic [31:0] reg_pc_w_val
);

    trap_state_t state_q;
    trap_state_t state_d;

    logic [31:0] latched_pc;
    logic [31:0] latched_cause;
    logic [31:0] latched_tval;
    logic        overrun_q;

    logic        save_en;
    logic        ret_en;
    logic        pc_op;
    logic [31:0] pc_val;
    logic        done;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            latched_pc    <= '0;
            latched_cause <= '0;
            latched_tval  <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && trap_req) begin
                latched_pc    <= trap_pc;
                latched_cause <= trap_cause;
                latched_tval  <= trap_tval;
            end
            if (state_q != IDLE && (trap_req || mret_req)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // A simultaneous trap and MRET in IDLE takes the trap; the MRET is dropped.
    always_comb begin
        state_d = state_q;
        save_en = 1'b0;
        ret_en  = 1'b0;
        pc_op   = 1'b0;
        pc_val  = '0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap_req) begin
                    state_d = SAVE;
                end else if (mret_req) begin
                    state_d = RET;
                end
            end
            SAVE: begin
                save_en = 1'b1;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                pc_op   = 1'b1;
                pc_val  = mtvec;
                done    = 1'b1;
                state_d = IDLE;
            end
            RET: begin
                ret_en  = 1'b1;
                pc_op   = 1'b1;
                pc_val  = mepc;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so an aborted redirect never leaks.
    assign busy         = rst_n && (state_q != IDLE);
    assign trap_done    = rst_n && done;
    assign trap_overrun = rst_n && overrun_q;
    assign reg_pc_w_op  = rst_n && pc_op;
    assign reg_pc_w_val = rst_n ? pc_val : 32'd0;

    env_trap_csr_file #(
        .RESET_MTVEC (RESET_MTVEC),
        .RESET_MIE   (RESET_MIE)
    ) u_csr_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .csr_addr   (csr_addr),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .save_en    (save_en && rst_n),
        .save_pc    (latched_pc),
        .save_cause (latched_cause),
        .save_tval  (latched_tval),
        .ret_en     (ret_en && rst_n),
        .mtvec      (mtvec),
        .mepc       (mepc)
    );

endmodule

// File: doc/env_trap_unit.md
Name: env_trap_unit

Overview:
Machine-mode trap responder on the receiving end of the ECALL/EBREAK/MRET environment instructions issued by the RV32I execute stage.
- Accepts a trap or return request from the executor.
- Saves trap state into the M-mode CSRs (mepc, mcause, mtval, mstatus.MIE/MPIE).
- Returns a one-cycle PC redirect (to mtvec on trap, to mepc on MRET) on the same reg_pc_w_op/reg_pc_w_val style write port the executors use.
- Provides a simple CSR read/write port for the Zicsr executor.

Parameters:
- RESET_MTVEC, 32'h0000_0100, trap vector after reset; bits [1:0] forced 0 (direct mode only).
- RESET_MIE, 1'b0, mstatus.MIE value after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- trap_req  in  1  single-cycle pulse: ECALL/EBREAK retired, take trap.
- trap_cause  in  32  mcause value (11 = ECALL from M, 3 = EBREAK).
- trap_pc  in  32  PC of the trapping instruction.
- trap_tval  in  32  mtval value (0 for ECALL, trap_pc for EBREAK).
- mret_req  in  1  single-cycle pulse: MRET retired.
- csr_addr  in  12  CSR address.
- csr_we  in  1  CSR write strobe.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  CSR read data, combinational from csr_addr.
- busy  out  1  high in any state other than IDLE.
- trap_done  out  1  one-cycle pulse coincident with the redirect.
- trap_overrun  out  1  sticky: a request arrived while busy.
- reg_pc_w_op  out  1  PC write enable, one-cycle pulse.
- reg_pc_w_val  out  32  PC write value; 0 when reg_pc_w_op = 0.

Behaviour:
- All state is updated on the rising edge of clk. The reset (rst_n = 0, sampled) applies the following:
  - state = IDLE.
  - mtvec = RESET_MTVEC & ~3; mepc = mcause = mtval = mscratch = 0.
  - MIE = RESET_MIE; MPIE = 0.
  - All outputs 0 except csr_rdata, which stays combinational.
- Reset mid-operation aborts any in-flight trap or return. No partial CSR update survives, and no redirect is issued.
- FSM states: IDLE, SAVE, REDIRECT, RET.
- IDLE:
  - trap_req = 1: latch trap_pc/trap_cause/trap_tval, go to SAVE.
  - Otherwise, mret_req = 1: go to RET.
  - Both asserted in the same cycle: trap wins and mret_req is dropped.
- SAVE (1 cycle):
  - mepc <= latched_pc & ~3; mcause <= cause; mtval <= tval.
  - MPIE <= MIE; MIE <= 0.
  - Go to REDIRECT.
- REDIRECT (1 cycle):
  - reg_pc_w_op = 1, reg_pc_w_val = mtvec, trap_done = 1.
  - Go to IDLE.
  - Trap latency: req cycle N, redirect visible in cycle N+2.
- RET (1 cycle):
  - reg_pc_w_op = 1, reg_pc_w_val = mepc, trap_done = 1.
  - MIE <= MPIE; MPIE <= 1.
  - Go to IDLE.
  - Return latency: req cycle N, redirect visible in cycle N+1.
- Requests when busy = 1 are ignored; trap_overrun is set and stays high until reset.
- CSR map (bit layouts):
  - 0x300 mstatus: only bit 3 (MIE) and bit 7 (MPIE) are writable; all other bits read 0.
  - 0x305 mtvec: writes clear bits [1:0].
  - 0x340 mscratch: full 32 bits.
  - 0x341 mepc: writes clear bits [1:0].
  - 0x342 mcause: full 32 bits.
  - 0x343 mtval: full 32 bits.
  - Unmapped addresses read 0; writes to them are ignored.
- CSR write timing and conflicts:
  - CSR writes take effect at the next edge.
  - A csr_we in the same cycle as a SAVE or RET update to the same register loses; the FSM update wins.
  - A csr_we in IDLE takes effect in the same edge that accepts trap_req. Example: an mtvec write takes effect before REDIRECT reads mtvec.
- Reads are combinational. A read of a register being written returns the old value.
- The mepc + 4 adjustment for resuming after ECALL is software's responsibility; the block never adds 4.

Decomposition:
- Shared package (csr_pkg) holds:
  - CSR address constants: CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL.
  - mcause constants: CAUSE_ECALL_M = 11, CAUSE_BREAKPOINT = 3.
  - mstatus bit indices: MSTATUS_MIE = 3, MSTATUS_MPIE = 7.
  - FSM state encoding.
- One sub-module is natural: env_trap_csr_file, which holds the CSR storage, read mux, write masking and FSM-update priority. The FSM stays in env_trap_unit.

Test Plan:
- Reset, then read every CSR: mtvec = 0x100, all other mapped CSRs = 0. Read 0x7C0: returns 0.
- ECALL: trap_pc = 0x0000_0040, cause = 11, tval = 0, MIE = 1.
  - Expect busy high for 2 cycles.
  - Expect reg_pc_w_op = 1 with val = 0x100 at N+2.
  - Expect mepc = 0x40, mcause = 11, MIE = 0, MPIE = 1.
- Write mepc = 0x44 via the CSR port, then pulse mret_req.
  - Expect redirect val = 0x44 at N+1.
  - Expect MIE = 1, MPIE = 1.
- Same-cycle conflicts:
  - trap_req and mret_req together with cause = 3, pc = 0x80: trap taken, mtval = 0x80, no RET redirect.
  - A second trap_req one cycle later (while busy): trap_overrun = 1, mepc stays 0x80.
- Write mtvec = 0x0000_0203: reads back 0x200, and the next ECALL redirects to 0x200.
- Reset asserted while in SAVE: no redirect occurs, and all CSRs hold their reset values next cycle.
